// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with a shared period counter.
//
// One counter (edge- or center-aligned) drives K_CH channels. Each channel compares the counter
// against its own threshold. The resulting reference r[c] drives a complementary high/low output
// pair, and dead time is inserted on every reference edge. Max, thresholds, dead time and mode
// are shadowed and are only taken at a period start.
//
// Ports:
//   i_clk          master clock
//   i_rst          asynchronous active-high reset
//   i_enable       global enable; low clears the counter, the references and the outputs
//   i_center       0 = edge aligned, 1 = center aligned (up/down)
//   i_max          counter top value
//   i_threshold    packed per-channel thresholds, channel c at [c*K_RES +: K_RES]
//   i_deadtime     dead time in clock cycles, common to all channels
//   o_pwm_h        high-side outputs
//   o_pwm_l        low-side (complementary) outputs
//   o_period_start one-cycle pulse after each period-start cycle
//   o_cnt          current counter value
`timescale 1ns/1ps

module pwm_gen_multi #(
  parameter int unsigned K_RES    = 16,
  parameter int unsigned K_CH     = 3,
  parameter int unsigned K_DT_RES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_center,
  input  logic [K_RES-1:0]      i_max,
  input  logic [K_CH*K_RES-1:0] i_threshold,
  input  logic [K_DT_RES-1:0]   i_deadtime,
  output logic [K_CH-1:0]       o_pwm_h,
  output logic [K_CH-1:0]       o_pwm_l,
  output logic                  o_period_start,
  output logic [K_RES-1:0]      o_cnt
);

  // Counter direction
  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  logic [K_RES-1:0]                cnt_q, cnt_d;
  logic                            dir_q, dir_d;
  logic [K_RES-1:0]                max_sh_q;
  logic [K_CH*K_RES-1:0]           thr_sh_q;
  logic [K_DT_RES-1:0]             dt_sh_q;
  logic                            center_sh_q;
  logic [K_CH-1:0]                 r_q, r_d;
  // r_q holds a reference computed in an enabled cycle; cleared while disabled
  logic                            valid_q, valid_d;
  logic [K_CH-1:0][K_DT_RES-1:0]   dtc_q, dtc_d;
  logic [K_CH-1:0]                 pwm_h_q, pwm_h_d;
  logic [K_CH-1:0]                 pwm_l_q, pwm_l_d;
  logic                            start_q, start_d;

  logic                            period_start;
  logic [K_RES-1:0]                max_eff;
  logic [K_CH*K_RES-1:0]           thr_eff;
  logic [K_DT_RES-1:0]             dt_eff;
  logic                            center_eff;

  // In the period-start cycle the shadows are being loaded, so that cycle already works with the
  // incoming values; otherwise the held shadow values apply.
  always_comb begin
    period_start = i_enable && (cnt_q == '0) && (dir_q == DirUp);
    max_eff      = period_start ? i_max       : max_sh_q;
    thr_eff      = period_start ? i_threshold : thr_sh_q;
    dt_eff       = period_start ? i_deadtime  : dt_sh_q;
    center_eff   = period_start ? i_center    : center_sh_q;
  end

  always_comb begin
    cnt_d   = '0;
    dir_d   = DirUp;
    r_d     = '0;
    valid_d = 1'b0;
    dtc_d   = '0;
    pwm_h_d = '0;
    pwm_l_d = '0;
    start_d = 1'b0;

    if (i_enable) begin
      start_d = period_start;
      valid_d = 1'b1;

      if (!center_eff) begin
        cnt_d = (cnt_q >= max_eff) ? '0 : cnt_q + 1'b1;
      end else if ((dir_q == DirUp) && (cnt_q < max_eff)) begin
        cnt_d = cnt_q + 1'b1;
      end else if (cnt_q == '0) begin
        // max of zero: counter parks at 0, every cycle starts a period
        cnt_d = '0;
      end else begin
        // Turn at the top or keep descending; direction is back to up whenever 0 is reached
        cnt_d = cnt_q - 1'b1;
        dir_d = (cnt_d != '0) ? DirDown : DirUp;
      end

      for (int c = 0; c < K_CH; c++) begin
        r_d[c] = cnt_q < thr_eff[c*K_RES +: K_RES];
        // Coming out of disable counts as an edge on every channel
        if (!valid_q || (r_d[c] != r_q[c])) begin
          dtc_d[c] = dt_eff;
        end else if (dtc_q[c] != '0) begin
          dtc_d[c] = dtc_q[c] - 1'b1;
        end else begin
          dtc_d[c] = '0;
        end
        // Both sides stay off while the dead-time counter runs
        pwm_h_d[c] = valid_q && (dtc_q[c] == '0) && r_q[c];
        pwm_l_d[c] = valid_q && (dtc_q[c] == '0) && !r_q[c];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q       <= '0;
      dir_q       <= DirUp;
      max_sh_q    <= '0;
      thr_sh_q    <= '0;
      dt_sh_q     <= '0;
      center_sh_q <= 1'b0;
      r_q         <= '0;
      valid_q     <= 1'b0;
      dtc_q       <= '0;
      pwm_h_q     <= '0;
      pwm_l_q     <= '0;
      start_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      dtc_q   <= dtc_d;
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
      start_q <= start_d;
      if (period_start) begin
        max_sh_q    <= i_max;
        thr_sh_q    <= i_threshold;
        dt_sh_q     <= i_deadtime;
        center_sh_q <= i_center;
      end
    end
  end

  assign o_pwm_h        = pwm_h_q;
  assign o_pwm_l        = pwm_l_q;
  assign o_period_start = start_q;
  assign o_cnt          = cnt_q;

endmodule
